// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment display path: glyph constants
// (gfedcba, active-high, bit0 = seg a), capture FSM encoding and the
// default settle length. The display driver encodes with the same glyphs.
package seven_segment_pkg;

  localparam int STABLE_CYCLES_DEFAULT = 16;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } cap_state_t;

endpackage

// File: rtl/seven_segment_capture_if.sv
// Display bus as seen by the capture block: segment lines and digit select
// driven by the display side, reconstructed value and strobes returned.
interface seven_segment_capture_if #(
  parameter int AW = 8,
  parameter int DW = 7
);
  logic [DW-1:0] led_port;
  logic          c;
  logic [AW-1:0] data;
  logic          valid;
  logic          err;

  modport master (output led_port, output c, input data, input valid, input err);
  modport slave  (input led_port, input c, output data, output valid, output err);
endinterface

// File: rtl/seven_segment_glyph_decode.sv
// Combinational glyph-to-nibble decoder; legal is low for any pattern that
// is not one of the 16 hex glyphs (00 included).
module seven_segment_glyph_decode
  import seven_segment_pkg::*;
#(
  parameter int DW = 7
) (
  input  logic [DW-1:0] seg,
  output logic [3:0]    nibble,
  output logic          legal
);

  // Map glyph pattern back to its hex value.
  always_comb begin
    nibble = 4'h0;
    legal  = 1'b1;
    case (seg)
      GLYPH_0: nibble = 4'h0;
      GLYPH_1: nibble = 4'h1;
      GLYPH_2: nibble = 4'h2;
      GLYPH_3: nibble = 4'h3;
      GLYPH_4: nibble = 4'h4;
      GLYPH_5: nibble = 4'h5;
      GLYPH_6: nibble = 4'h6;
      GLYPH_7: nibble = 4'h7;
      GLYPH_8: nibble = 4'h8;
      GLYPH_9: nibble = 4'h9;
      GLYPH_A: nibble = 4'hA;
      GLYPH_B: nibble = 4'hB;
      GLYPH_C: nibble = 4'hC;
      GLYPH_D: nibble = 4'hD;
      GLYPH_E: nibble = 4'hE;
      GLYPH_F: nibble = 4'hF;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_segment_capture.sv
// Seven-segment bus capture: synchronizes the segment/digit-select pins,
// waits for each digit phase to settle, decodes the glyph and publishes
// {hi, lo} with a one-cycle valid strobe (err strobe on illegal glyph).
// Build option SEG_CAPTURE_CHANGE_ONLY_EN: valid only when the frame value
// differs from the current data (first frame after reset always pulses).
//
// state  | meaning
// IDLE   | after reset, waiting for the first digit-select edge
// SETTLE | counting unchanged samples of {c, led_port}
// HOLD   | glyph taken for this phase, waiting for the next c edge
module seven_segment_capture
  import seven_segment_pkg::*;
#(
  parameter int AW            = 8,
  parameter int DW            = 7,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  seven_segment_capture_if.slave bus
);

  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(STABLE_CYCLES - 1);

  logic [DW-1:0] led_s1, led_s2, led_prev;
  logic          c_s1, c_s2, c_prev;

  cap_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    hi, hi_nxt, lo, lo_nxt;
  logic          got_hi, got_hi_nxt, got_lo, got_lo_nxt;
  logic [AW-1:0] data_q, data_nxt;
  logic          valid_q, valid_nxt, err_q, err_nxt;
  logic [AW-1:0] frame;
  logic          publish_ok;
  logic          c_chg, seg_chg;
  logic [3:0]    nibble;
  logic          legal;

  seven_segment_glyph_decode #(.DW(DW)) u_decode (
    .seg    (led_s2),
    .nibble (nibble),
    .legal  (legal)
  );

  // Two-flop synchronizers plus a delayed copy for change detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_s1   <= '0;
      led_s2   <= '0;
      led_prev <= '0;
      c_s1     <= 1'b0;
      c_s2     <= 1'b0;
      c_prev   <= 1'b0;
    end else begin
      led_s1   <= bus.led_port;
      led_s2   <= led_s1;
      led_prev <= led_s2;
      c_s1     <= bus.c;
      c_s2     <= c_s1;
      c_prev   <= c_s2;
    end
  end

  assign c_chg   = c_s2 ^ c_prev;
  assign seg_chg = (led_s2 != led_prev);
  assign frame   = {hi, nibble};

`ifdef SEG_CAPTURE_CHANGE_ONLY_EN
  logic published, published_nxt;

  // Remembers whether any frame has been published since reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) published <= 1'b0;
    else       published <= published_nxt;
  end

  assign publish_ok = !published || (frame != data_q);
`else
  assign publish_ok = 1'b1;
`endif

  // State, counter, captured nibbles and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      hi      <= 4'h0;
      lo      <= 4'h0;
      got_hi  <= 1'b0;
      got_lo  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      hi      <= hi_nxt;
      lo      <= lo_nxt;
      got_hi  <= got_hi_nxt;
      got_lo  <= got_lo_nxt;
      data_q  <= data_nxt;
      valid_q <= valid_nxt;
      err_q   <= err_nxt;
    end
  end

  // Next-state, settle timer (down-count to zero) and capture/publish logic.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    hi_nxt     = hi;
    lo_nxt     = lo;
    got_hi_nxt = got_hi;
    got_lo_nxt = got_lo;
    data_nxt   = data_q;
    valid_nxt  = 1'b0;
    err_nxt    = 1'b0;
`ifdef SEG_CAPTURE_CHANGE_ONLY_EN
    published_nxt = published;
`endif
    case (state)
      ST_IDLE: begin
        if (c_chg) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = CNT_LOAD;
        end
      end
      ST_SETTLE: begin
        if (c_chg || seg_chg) begin
          // A digit-select edge mid-settle means a phase was missed, so a
          // pending hi nibble must not pair with the next lo.
          cnt_nxt = CNT_LOAD;
          if (c_chg) got_hi_nxt = 1'b0;
        end else if (cnt == '0) begin
          state_nxt = ST_HOLD;
          if (!legal) begin
            err_nxt    = 1'b1;
            got_hi_nxt = 1'b0;
            got_lo_nxt = 1'b0;
          end else if (c_s2) begin
            hi_nxt     = nibble;
            got_hi_nxt = 1'b1;
          end else begin
            lo_nxt     = nibble;
            got_lo_nxt = 1'b1;
            if (got_hi) begin
              data_nxt   = frame;
              valid_nxt  = publish_ok;
              got_hi_nxt = 1'b0;
              got_lo_nxt = 1'b0;
`ifdef SEG_CAPTURE_CHANGE_ONLY_EN
              published_nxt = 1'b1;
`endif
            end
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_HOLD: begin
        if (c_chg) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = CNT_LOAD;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Scoreboard bench for seven_segment_capture: expected valid/err events are
// queued as frames are driven and matched against DUT strobes on negedge.
module tb_seven_segment_capture;

  logic clk;
  logic reset;

  seven_segment_capture_if #(.AW(8), .DW(7)) bus ();

  seven_segment_capture #(.AW(8), .DW(7), .STABLE_CYCLES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] d;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  logic [6:0] g[16];
  logic [7:0] model_data;
  bit         model_first;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Match every strobe against the next queued expectation.
  always @(negedge clk) begin
    if (!reset && (bus.valid || bus.err)) begin
      chk("exclusive", {31'd0, bus.valid & bus.err}, 32'd0);
      if (sb.size() == 0) begin
        chk("spurious", {30'd0, bus.valid, bus.err}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("kind_err", {31'd0, bus.err}, {31'd0, e.is_err});
        if (bus.valid) chk("data", {24'd0, bus.data}, {24'd0, e.d});
      end
    end
  end

  task automatic drive(input logic cv, input logic [6:0] seg, input int n);
    bus.c = cv;
    bus.led_port = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [7:0] v);
    exp_t e;
    e.is_err = 1'b0;
    e.d = v;
`ifdef SEG_CAPTURE_CHANGE_ONLY_EN
    if (model_first || v != model_data) sb.push_back(e);
`else
    sb.push_back(e);
`endif
    model_data  = v;
    model_first = 1'b0;
  endtask

  task automatic frame(input logic [3:0] h, input logic [3:0] l, input int n);
    drive(1'b1, g[h], n);
    push_frame({h, l});
    drive(1'b0, g[l], n);
  endtask

  initial begin
    exp_t ee;
    g = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    model_data  = 8'h00;
    model_first = 1'b1;
    reset = 1'b1;
    bus.c = 1'b0;
    bus.led_port = 7'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", {24'd0, bus.data}, 32'd0);
    chk("rst_valid", {31'd0, bus.valid}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    reset = 1'b0;
    drive(1'b0, 7'h00, 5);

    // Steady frame E5.
    frame(4'hE, 4'h5, 40);
    chk("steady_data", {24'd0, bus.data}, {24'd0, model_data});

    // Illegal lo glyph: err, no valid, data unchanged.
    drive(1'b1, 7'h3F, 40);
    ee.is_err = 1'b1;
    ee.d = 8'h00;
    sb.push_back(ee);
    drive(1'b0, 7'h00, 40);
    chk("illegal_data", {24'd0, bus.data}, 32'h0000_00E5);

    // Glitching hi phase, 06/07 every 5 cycles, then held at 06.
    for (int i = 0; i < 6; i++) drive(1'b1, (i % 2) ? 7'h07 : 7'h06, 5);
    drive(1'b1, 7'h06, 40);
    push_frame(8'h12);
    drive(1'b0, 7'h5B, 40);
    chk("glitch_data", {24'd0, bus.data}, 32'h0000_0012);

    // Short hi phase is missed, lo alone publishes nothing.
    drive(1'b1, 7'h7F, 10);
    drive(1'b0, 7'h3F, 40);
    chk("short_data", {24'd0, bus.data}, 32'h0000_0012);

    // Reset after a hi capture abandons the frame.
    drive(1'b1, 7'h66, 40);
    reset = 1'b1;
    bus.c = 1'b0;
    bus.led_port = 7'h4F;
    model_data  = 8'h00;
    model_first = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_data", {24'd0, bus.data}, 32'd0);
    reset = 1'b0;
    drive(1'b0, 7'h4F, 40);
    chk("post_rst_data", {24'd0, bus.data}, 32'd0);
    frame(4'h6, 4'h3, 40);
    chk("post_rst_frame", {24'd0, bus.data}, 32'h0000_0063);

    // Two identical frames A7.
    frame(4'hA, 4'h7, 40);
    frame(4'hA, 4'h7, 40);
    chk("repeat_data", {24'd0, bus.data}, 32'h0000_00A7);

    // Random frames across the full glyph set.
    for (int i = 0; i < 6; i++) begin
      logic [3:0] h, l;
      h = 4'($urandom_range(0, 15));
      l = 4'($urandom_range(0, 15));
      frame(h, l, 30);
      chk("rand_data", {24'd0, bus.data}, {24'd0, model_data});
    end

    drive(1'b0, g[0], 10);
    chk("sb_drain", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
